branch_resolve_queue: RTL and testbench

- Parametrised branch/jump resolution unit with a DEPTH-entry in-order queue of issued control-flow instructions awaiting the PC of their successor.
- Comparison and target calculation happen in the issue cycle. Each entry resolves when the following instruction's PC arrives, then reports predictor results and a redirect (flush).
- Sits beside the ALU in the execute group. Feeds the branch predictor/RAS and the fetch redirect path.

---
 rtl/branch_resolve_queue.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Branch/jump resolution unit: resolves control-flow instructions in the issue cycle
// and holds them in order until the successor PC arrives. Optional macro: BR_COMPRESSED_EN.
module branch_resolve_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ID_W-1:0]          issue_id,
  input  logic [1:0]               issue_type,
  input  logic [2:0]               issue_fn3,
  input  logic [XLEN-1:0]          issue_pc,
  input  logic [XLEN-1:0]          issue_rs1,
  input  logic [XLEN-1:0]          issue_rs2,
  input  logic [20:0]              issue_offset,
  input  logic                     issue_is_call,
  input  logic                     issue_is_return,
  input  logic                     issue_compressed,
  input  logic                     next_pc_valid,
  input  logic [XLEN-1:0]          next_pc,
  input  logic                     flush,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [XLEN-1:0]          res_pc,
  output logic [XLEN-1:0]          res_target,
  output logic                     res_taken,
  output logic                     res_is_branch,
  output logic                     res_is_call,
  output logic                     res_is_return,
  output logic                     branch_flush,
  output logic                     exc_valid,
  output logic [ID_W-1:0]          exc_id,
  output logic [XLEN-1:0]          exc_pc,
  output logic [XLEN-1:0]          exc_tval,
  output logic [$clog2(DEPTH):0]   pending_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            is_branch;
    logic            is_call;
    logic            is_return;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            new_entry;
  entry_t            head;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              exc_valid_q, exc_valid_d;
  logic [ID_W-1:0]   exc_id_q, exc_id_d;
  logic [XLEN-1:0]   exc_pc_q, exc_pc_d, exc_tval_q, exc_tval_d;

  logic              sgn, lt, eq, cmp, taken, is_jalr, misaligned;
  logic [XLEN:0]     op_a, op_b;
  logic [XLEN-1:0]   off_sext, jump_sum, jump, fallthrough, target;
  logic              empty, full, pop, push, accept, clear;
  logic              unused_bits;

  // Issue-cycle compare and target computation
  always_comb begin
    sgn         = ~(issue_fn3[2] & issue_fn3[1]);
    op_a        = {sgn & issue_rs1[XLEN-1], issue_rs1};
    op_b        = {sgn & issue_rs2[XLEN-1], issue_rs2};
    lt          = $signed(op_a) < $signed(op_b);
    eq          = (op_a == op_b);
    cmp         = (issue_fn3[2] ? lt : eq) ^ issue_fn3[0];
    taken       = cmp | issue_type[0];
    is_jalr     = (issue_type == 2'b01);
    off_sext    = {{(XLEN-21){issue_offset[20]}}, issue_offset};
    jump_sum    = (is_jalr ? issue_rs1 : issue_pc) + off_sext;
    jump        = {jump_sum[XLEN-1:1], jump_sum[0] & ~is_jalr};
`ifdef BR_COMPRESSED_EN
    fallthrough = issue_pc + (issue_compressed ? XLEN'(2) : XLEN'(4));
    target      = taken ? jump : fallthrough;
    misaligned  = 1'b0;
`else
    fallthrough = issue_pc + XLEN'(4);
    target      = taken ? jump : fallthrough;
    misaligned  = taken & target[1];
`endif
  end

`ifdef BR_COMPRESSED_EN
  assign unused_bits = next_pc[0];
`else
  assign unused_bits = next_pc[0] ^ issue_compressed;
`endif

  always_comb begin
    new_entry.id        = issue_id;
    new_entry.pc        = issue_pc;
    new_entry.target    = target;
    new_entry.taken     = taken;
    new_entry.is_branch = (issue_type == 2'b00);
    new_entry.is_call   = issue_is_call;
    new_entry.is_return = issue_is_return;
  end

  assign head          = mem_q[head_q];
  assign empty         = (count_q == '0);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign issue_ready   = ~full;
  assign res_valid     = ~empty & next_pc_valid;
  assign pop           = res_valid;
  assign branch_flush  = res_valid & (next_pc[XLEN-1:1] != head.target[XLEN-1:1]);
  assign clear         = flush | branch_flush;
  assign accept        = issue_valid & issue_ready & ~clear;
  assign push          = accept & ~misaligned;

  assign res_id        = head.id;
  assign res_pc        = head.pc;
  assign res_target    = head.target;
  assign res_taken     = head.taken;
  assign res_is_branch = head.is_branch;
  assign res_is_call   = head.is_call;
  assign res_is_return = head.is_return;

  // Queue pointer / count update; a redirect or flush empties the queue
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Misaligned target raises a one-cycle exception pulse
  always_comb begin
    exc_valid_d = accept & misaligned;
    exc_id_d    = exc_id_q;
    exc_pc_d    = exc_pc_q;
    exc_tval_d  = exc_tval_q;
    if (exc_valid_d) begin
      exc_id_d   = issue_id;
      exc_pc_d   = issue_pc;
      exc_tval_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_id_q    <= '0;
      exc_pc_q    <= '0;
      exc_tval_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      exc_valid_q <= exc_valid_d;
      exc_id_q    <= exc_id_d;
      exc_pc_q    <= exc_pc_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= new_entry;
  end

  assign exc_valid     = exc_valid_q;
  assign exc_id        = exc_id_q;
  assign exc_pc        = exc_pc_q;
  assign exc_tval      = exc_tval_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (default parameters).
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_id;
  logic [1:0]  issue_type;
  logic [2:0]  issue_fn3;
  logic [31:0] issue_pc, issue_rs1, issue_rs2;
  logic [20:0] issue_offset;
  logic        issue_is_call, issue_is_return, issue_compressed;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        flush;
  logic        res_valid;
  logic [2:0]  res_id;
  logic [31:0] res_pc, res_target;
  logic        res_taken, res_is_branch, res_is_call, res_is_return;
  logic        branch_flush, exc_valid;
  logic [2:0]  exc_id;
  logic [31:0] exc_pc, exc_tval;
  logic [2:0]  pending_count;

  int checks = 0;
  int failures = 0;

  branch_resolve_queue #(.XLEN(32), .DEPTH(4), .ID_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_type(issue_type), .issue_fn3(issue_fn3), .issue_pc(issue_pc),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_offset(issue_offset),
    .issue_is_call(issue_is_call), .issue_is_return(issue_is_return),
    .issue_compressed(issue_compressed),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc), .flush(flush),
    .res_valid(res_valid), .res_id(res_id), .res_pc(res_pc), .res_target(res_target),
    .res_taken(res_taken), .res_is_branch(res_is_branch), .res_is_call(res_is_call),
    .res_is_return(res_is_return), .branch_flush(branch_flush),
    .exc_valid(exc_valid), .exc_id(exc_id), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; next_pc_valid = 1'b0; flush = 1'b0;
    issue_is_call = 1'b0; issue_is_return = 1'b0; issue_compressed = 1'b0;
  endtask

  task automatic do_issue(input logic [2:0] id, input logic [1:0] typ, input logic [2:0] fn3,
                          input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [20:0] off, input logic call);
    issue_valid = 1'b1; issue_id = id; issue_type = typ; issue_fn3 = fn3;
    issue_pc = pc; issue_rs1 = rs1; issue_rs2 = rs2; issue_offset = off;
    issue_is_call = call; issue_is_return = 1'b0; issue_compressed = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] npc);
    next_pc_valid = 1'b1; next_pc = npc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle();
    issue_id = '0; issue_type = '0; issue_fn3 = '0; issue_pc = '0;
    issue_rs1 = '0; issue_rs2 = '0; issue_offset = '0; next_pc = '0;
    #12;
    check_eq("rst_count", 64'(pending_count), 64'd0);
    check_eq("rst_ready", 64'(issue_ready), 64'd1);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_exc", 64'(exc_valid), 64'd0);
    check_eq("rst_exc_tval", 64'(exc_tval), 64'd0);
    step(); rst = 1'b0; step();

    // BEQ taken but successor is fallthrough -> redirect
    do_issue(3'd1, 2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 21'h20, 1'b0);
    step(); idle();
    check_eq("beq_count", 64'(pending_count), 64'd1);
    resolve(32'h104); #2;
    check_eq("beq_valid", 64'(res_valid), 64'd1);
    check_eq("beq_taken", 64'(res_taken), 64'd1);
    check_eq("beq_target", 64'(res_target), 64'h120);
    check_eq("beq_id", 64'(res_id), 64'd1);
    check_eq("beq_isbr", 64'(res_is_branch), 64'd1);
    check_eq("beq_flush", 64'(branch_flush), 64'd1);
    step(); idle();
    check_eq("beq_count_after", 64'(pending_count), 64'd0);

    // BLTU unsigned: 0xFFFFFFFF < 1 is false
    do_issue(3'd2, 2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 21'h40, 1'b0);
    step(); idle();
    resolve(32'h204); #2;
    check_eq("bltu_taken", 64'(res_taken), 64'd0);
    check_eq("bltu_target", 64'(res_target), 64'h204);
    check_eq("bltu_flush", 64'(branch_flush), 64'd0);
    step(); idle();

    // BLT signed: -1 < 1 is true
    do_issue(3'd3, 2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 21'h40, 1'b0);
    step(); idle();
    resolve(32'h240); #2;
    check_eq("blt_taken", 64'(res_taken), 64'd1);
    check_eq("blt_flush", 64'(branch_flush), 64'd0);
    step(); idle();

    // JALR with misaligned target (bit1 set after clearing bit0)
    do_issue(3'd4, 2'b01, 3'b000, 32'h300, 32'h1001, 32'd0, 21'd2, 1'b0);
    step(); idle();
`ifdef BR_COMPRESSED_EN
    check_eq("jalr_exc", 64'(exc_valid), 64'd0);
    check_eq("jalr_count", 64'(pending_count), 64'd1);
    resolve(32'h1002); #2;
    check_eq("jalr_target", 64'(res_target), 64'h1002);
    check_eq("jalr_flush", 64'(branch_flush), 64'd0);
    step(); idle();
`else
    check_eq("jalr_exc", 64'(exc_valid), 64'd1);
    check_eq("jalr_tval", 64'(exc_tval), 64'h1002);
    check_eq("jalr_epc", 64'(exc_pc), 64'h300);
    check_eq("jalr_eid", 64'(exc_id), 64'd4);
    check_eq("jalr_count", 64'(pending_count), 64'd0);
    step();
    check_eq("jalr_exc_pulse", 64'(exc_valid), 64'd0);
`endif

    // JAL call, negative offset; next_pc bit0 does not matter for the compare
    do_issue(3'd5, 2'b11, 3'b000, 32'h400, 32'd0, 32'd0, 21'h1F_FFF8, 1'b1);
    step(); idle();
    resolve(32'h3F9); #2;
    check_eq("jal_target", 64'(res_target), 64'h3F8);
    check_eq("jal_call", 64'(res_is_call), 64'd1);
    check_eq("jal_isbr", 64'(res_is_branch), 64'd0);
    check_eq("jal_flush", 64'(branch_flush), 64'd0);
    step(); idle();

    // Fill to DEPTH with BNE taken, ids wrap 5,6,7,0
    for (int i = 0; i < 4; i++) begin
      do_issue(3'(5 + i), 2'b00, 3'b001, 32'h500 + 32'(16 * i), 32'd1, 32'd2, 21'h10, 1'b0);
      step();
    end
    idle(); #2;
    check_eq("full_count", 64'(pending_count), 64'd4);
    check_eq("full_ready", 64'(issue_ready), 64'd0);
    do_issue(3'd1, 2'b00, 3'b001, 32'h540, 32'd1, 32'd2, 21'h10, 1'b0);
    resolve(32'h510); #2;
    check_eq("full_pop_valid", 64'(res_valid), 64'd1);
    check_eq("full_pop_id", 64'(res_id), 64'd5);
    check_eq("full_pop_ready", 64'(issue_ready), 64'd0);
    step(); idle();
    check_eq("after_pop_count", 64'(pending_count), 64'd3);
    check_eq("after_pop_ready", 64'(issue_ready), 64'd1);
    do_issue(3'd1, 2'b00, 3'b001, 32'h540, 32'd1, 32'd2, 21'h10, 1'b0);
    resolve(32'h520); #2;
    check_eq("pushpop_id", 64'(res_id), 64'd6);
    step(); idle();
    check_eq("pushpop_count", 64'(pending_count), 64'd3);
    begin
      logic [2:0]  exp_id [3];
      logic [31:0] exp_tg [3];
      exp_id[0] = 3'd7; exp_id[1] = 3'd0; exp_id[2] = 3'd1;
      exp_tg[0] = 32'h530; exp_tg[1] = 32'h540; exp_tg[2] = 32'h550;
      for (int i = 0; i < 3; i++) begin
        resolve(exp_tg[i]); #2;
        check_eq("order_id", 64'(res_id), 64'(exp_id[i]));
        check_eq("order_flush", 64'(branch_flush), 64'd0);
        step(); idle();
      end
    end
    check_eq("drain_count", 64'(pending_count), 64'd0);

    // Head mispredicts with 3 pending and a concurrent issue
    for (int i = 0; i < 3; i++) begin
      do_issue(3'(2 + i), 2'b00, 3'b000, 32'h600 + 32'(16 * i), 32'd0, 32'd0, 21'h8, 1'b0);
      step();
    end
    idle();
    check_eq("mp_count", 64'(pending_count), 64'd3);
    do_issue(3'd5, 2'b00, 3'b000, 32'h630, 32'd0, 32'd0, 21'h8, 1'b0);
    resolve(32'h604); #2;
    check_eq("mp_flush", 64'(branch_flush), 64'd1);
    check_eq("mp_id", 64'(res_id), 64'd2);
    step(); idle();
    resolve(32'h608); #2;
    check_eq("mp_count_after", 64'(pending_count), 64'd0);
    check_eq("mp_empty_res", 64'(res_valid), 64'd0);
    step(); idle();

    // External flush drops queue and the same-cycle push
    do_issue(3'd6, 2'b00, 3'b000, 32'h700, 32'd0, 32'd0, 21'h8, 1'b0); step();
    do_issue(3'd7, 2'b00, 3'b000, 32'h710, 32'd0, 32'd0, 21'h8, 1'b0); step();
    do_issue(3'd0, 2'b00, 3'b000, 32'h720, 32'd0, 32'd0, 21'h8, 1'b0);
    flush = 1'b1;
    step(); idle();
    check_eq("flush_count", 64'(pending_count), 64'd0);

    // Async reset with entries pending and an exception queued
    do_issue(3'd1, 2'b00, 3'b000, 32'h800, 32'd0, 32'd0, 21'h8, 1'b0); step();
    do_issue(3'd2, 2'b00, 3'b000, 32'h810, 32'd0, 32'd0, 21'h8, 1'b0); step();
    do_issue(3'd3, 2'b01, 3'b000, 32'h820, 32'h1001, 32'd0, 21'd2, 1'b0); step();
    idle(); #2;
`ifndef BR_COMPRESSED_EN
    check_eq("prerst_exc", 64'(exc_valid), 64'd1);
    check_eq("prerst_count", 64'(pending_count), 64'd2);
`endif
    rst = 1'b1; #1;
    check_eq("midrst_count", 64'(pending_count), 64'd0);
    check_eq("midrst_exc", 64'(exc_valid), 64'd0);
    step(); rst = 1'b0;
    resolve(32'h808); #2;
    check_eq("postrst_res", 64'(res_valid), 64'd0);
    step(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
